// File: rtl/regfile_mp_if.sv
// Register file access bundle: read ports, two write lanes, clear/ready.
// Master drives requests; the register file is the slave.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic                       clear;
  logic                       ready;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic                       wr_en0;
  logic [ADDR_W-1:0]          wr_addr0;
  logic [DATA_W-1:0]          wr_data0;
  logic                       wr_en1;
  logic [ADDR_W-1:0]          wr_addr1;
  logic [DATA_W-1:0]          wr_data1;

  modport master (
    output clear, rd_addr,
    output wr_en0, wr_addr0, wr_data0,
    output wr_en1, wr_addr1, wr_data1,
    input  ready, rd_data
  );

  modport slave (
    input  clear, rd_addr,
    input  wr_en0, wr_addr0, wr_data0,
    input  wr_en1, wr_addr1, wr_data1,
    output ready, rd_data
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with sweep-based clear.
// Storage has no reset so it can map onto RAM.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
  logic                ready_q;
  logic                sweep_we;
  logic                wr0_ok, wr1_ok;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    sweep_we  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        sweep_we  = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == (ADDR_W+1)'(DEPTH-1))
          state_d = RUN;
      end
      RUN: begin
        if (bus.clear) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // lane 0 yields to lane 1 on an address collision
  always_comb begin
    wr0_ok = bus.wr_en0 && (state_q == RUN);
    wr1_ok = bus.wr_en1 && (state_q == RUN);
    if (ZERO_REG && bus.wr_addr0 == '0) wr0_ok = 1'b0;
    if (ZERO_REG && bus.wr_addr1 == '0) wr1_ok = 1'b0;
    if (bus.wr_en1 && bus.wr_addr1 == bus.wr_addr0)
      wr0_ok = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we)
        mem_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
      if (wr0_ok)
        mem_q[bus.wr_addr0] <= bus.wr_data0;
      if (wr1_ok)
        mem_q[bus.wr_addr1] <= bus.wr_data1;
    end
  end

  assign bus.ready = ready_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem_q[ra];
      if (BYPASS && bus.wr_en0 && bus.wr_addr0 == ra)
        rv = bus.wr_data0;
      if (BYPASS && bus.wr_en1 && bus.wr_addr1 == ra)
        rv = bus.wr_data1;
      if (ZERO_REG && ra == '0)
        rv = '0;
      if (!ready_q)
        rv = '0;
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = rv;
  end
endmodule
